// File: rtl/arf_retire_ctrl.sv
// In-order commit FIFO feeding the two ARF write ports; up to two pushes and two pops per cycle.
// Two-cycle accept-to-write latency with no empty bypass; in_ready drops when fewer than two entries are free.
module arf_retire_ctrl #(
  parameter int AR_SIZE = 6,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   c0_valid,
  input  logic [AR_SIZE-1:0]     c0_addr,
  input  logic [DATA_W-1:0]      c0_data,
  input  logic                   c1_valid,
  input  logic [AR_SIZE-1:0]     c1_addr,
  input  logic [DATA_W-1:0]      c1_data,
  output logic                   in_ready,
  input  logic                   drain_en,
  output logic                   write_en,
  output logic [AR_SIZE-1:0]     write_addr1,
  output logic [DATA_W-1:0]      write_data1,
  output logic [AR_SIZE-1:0]     write_addr2,
  output logic [DATA_W-1:0]      write_data2,
  output logic                   pending,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [31:0]            retired_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AR_SIZE-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr, rd_ptr1, wr_idx1;

  logic               push0, push1;
  logic [1:0]         n_push, n_pop, n_wr;
  logic [AR_SIZE-1:0] head_a0, head_a1, nxt_a1, nxt_a2;
  logic [DATA_W-1:0]  head_d0, head_d1, nxt_d1, nxt_d2;

  // Space is judged on the current count only; a same-cycle pop never frees room.
  assign in_ready = (fifo_count <= CW'(DEPTH - 2));
  assign push0    = in_ready & c0_valid & (c0_addr != '0);
  assign push1    = in_ready & c0_valid & c1_valid & (c1_addr != '0);
  assign n_push   = {1'b0, push0} + {1'b0, push1};
  assign wr_idx1  = wr_ptr + PW'(push0);
  assign rd_ptr1  = rd_ptr + PW'(1);

  assign head_a0 = addr_mem[rd_ptr];
  assign head_d0 = data_mem[rd_ptr];
  assign head_a1 = addr_mem[rd_ptr1];
  assign head_d1 = data_mem[rd_ptr1];

  always_comb begin
    n_pop  = 2'd0;
    nxt_a1 = '0;
    nxt_d1 = '0;
    nxt_a2 = '0;
    nxt_d2 = '0;
    if (drain_en) begin
      n_pop = (fifo_count >= CW'(2)) ? 2'd2 : fifo_count[1:0];
    end
    if (n_pop != 2'd0) begin
      nxt_a1 = head_a0;
      nxt_d1 = head_d0;
    end
    if (n_pop == 2'd2) begin
      nxt_a2 = head_a1;
      nxt_d2 = head_d1;
      // Same destination in one pair: only the younger value may land.
      if ((head_a0 == head_a1) && (head_a0 != '0)) begin
        nxt_a1 = '0;
        nxt_d1 = '0;
      end
    end
    n_wr = {1'b0, (nxt_a1 != '0)} + {1'b0, (nxt_a2 != '0)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      write_en    <= 1'b0;
      write_addr1 <= '0;
      write_data1 <= '0;
      write_addr2 <= '0;
      write_data2 <= '0;
      retired_cnt <= '0;
    end else begin
      rd_ptr      <= rd_ptr + PW'(n_pop);
      wr_ptr      <= wr_ptr + PW'(n_push);
      fifo_count  <= fifo_count + CW'(n_push) - CW'(n_pop);
      write_en    <= (n_pop != 2'd0);
      write_addr1 <= nxt_a1;
      write_data1 <= nxt_d1;
      write_addr2 <= nxt_a2;
      write_data2 <= nxt_d2;
      retired_cnt <= retired_cnt + 32'(n_wr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push0) begin
        addr_mem[wr_ptr] <= c0_addr;
        data_mem[wr_ptr] <= c0_data;
      end
      if (push1) begin
        addr_mem[wr_idx1] <= c1_addr;
        data_mem[wr_idx1] <= c1_data;
      end
    end
  end

  assign pending = (fifo_count != '0) | write_en;

endmodule

// File: tb/tb_arf_retire_ctrl.sv
// Bench for arf_retire_ctrl: directed vector table, hand-written backpressure/reset sequences,
// and randomized traffic compared every cycle against a queue-based reference model.
module tb_arf_retire_ctrl;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c0_valid = 1'b0, c1_valid = 1'b0, drain_en = 1'b0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [DW-1:0] c0_data = '0, c1_data = '0;
  logic          in_ready, write_en, pending;
  logic [AW-1:0] write_addr1, write_addr2;
  logic [DW-1:0] write_data1, write_data2;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [31:0]   retired_cnt;

  always #5 clk = ~clk;

  arf_retire_ctrl #(.AR_SIZE(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .c0_valid(c0_valid), .c0_addr(c0_addr), .c0_data(c0_data),
    .c1_valid(c1_valid), .c1_addr(c1_addr), .c1_data(c1_data),
    .in_ready(in_ready), .drain_en(drain_en),
    .write_en(write_en),
    .write_addr1(write_addr1), .write_data1(write_data1),
    .write_addr2(write_addr2), .write_data2(write_data2),
    .pending(pending), .fifo_count(fifo_count), .retired_cnt(retired_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO as a queue of entries, output registers as plain variables.
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          q[$];
  logic          m_we;
  logic [AW-1:0] m_a1, m_a2;
  logic [DW-1:0] m_d1, m_d2;
  logic [31:0]   m_ret;

  task automatic model_edge();
    int   npop;
    bit   acc;
    ent_t e1, e2;
    if (rst) begin
      q.delete();
      m_we = 0; m_a1 = '0; m_d1 = '0; m_a2 = '0; m_d2 = '0; m_ret = '0;
    end else begin
      acc  = (DEPTH - q.size()) >= 2;
      npop = drain_en ? ((q.size() < 2) ? q.size() : 2) : 0;
      m_we = (npop > 0);
      m_a1 = '0; m_d1 = '0; m_a2 = '0; m_d2 = '0;
      if (npop >= 1) begin e1 = q.pop_front(); m_a1 = e1.a; m_d1 = e1.d; end
      if (npop == 2) begin
        e2 = q.pop_front(); m_a2 = e2.a; m_d2 = e2.d;
        if (e1.a == e2.a && e1.a != 0) begin m_a1 = '0; m_d1 = '0; end
      end
      m_ret = m_ret + ((m_a1 != 0) ? 1 : 0) + ((m_a2 != 0) ? 1 : 0);
      if (acc && c0_valid) begin
        if (c0_addr != 0) q.push_back('{a: c0_addr, d: c0_data});
        if (c1_valid && c1_addr != 0) q.push_back('{a: c1_addr, d: c1_data});
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("m.we",    32'(write_en),    32'(m_we));
    chk("m.a1",    32'(write_addr1), 32'(m_a1));
    chk("m.d1",    write_data1,      m_d1);
    chk("m.a2",    32'(write_addr2), 32'(m_a2));
    chk("m.d2",    write_data2,      m_d2);
    chk("m.cnt",   32'(fifo_count),  32'(q.size()));
    chk("m.rdy",   32'(in_ready),    32'((DEPTH - q.size()) >= 2));
    chk("m.pend",  32'(pending),     32'((q.size() != 0) || m_we));
    chk("m.ret",   retired_cnt,      m_ret);
  endtask

  task automatic drive(input logic r, input logic dr, input logic v0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic v1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1);
    rst = r; drain_en = dr;
    c0_valid = v0; c0_addr = a0; c0_data = d0;
    c1_valid = v1; c1_addr = a1; c1_data = d1;
  endtask

  typedef struct {
    logic [31:0] rst, drn, c0v, c0a, c0d, c1v, c1a, c1d;
    logic [31:0] we, a1, d1, a2, d2, cnt, rdy, pend, ret;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [31:0] r, dr, v0, a0, d0, v1, a1, d1,
                     input logic [31:0] we, wa1, wd1, wa2, wd2, cnt, rdy, pend, ret);
    vec_t v;
    v.rst = r; v.drn = dr; v.c0v = v0; v.c0a = a0; v.c0d = d0; v.c1v = v1; v.c1a = a1; v.c1d = d1;
    v.we = we; v.a1 = wa1; v.d1 = wd1; v.a2 = wa2; v.d2 = wd2;
    v.cnt = cnt; v.rdy = rdy; v.pend = pend; v.ret = ret;
    vecs.push_back(v);
  endtask

  initial begin
    //   rst drn c0v c0a c0d           c1v c1a c1d  | we a1 d1            a2 d2    cnt rdy pend ret
    add(1, 1, 1, 5, 32'h1,          0, 0, 0,        0, 0, 0,            0, 0,     0, 1, 0, 0);
    add(1, 1, 1, 5, 32'h1,          0, 0, 0,        0, 0, 0,            0, 0,     0, 1, 0, 0);
    add(0, 1, 1, 5, 32'hDEADBEEF,   0, 0, 0,        0, 0, 0,            0, 0,     1, 1, 1, 0);
    add(0, 1, 0, 0, 0,              0, 0, 0,        1, 5, 32'hDEADBEEF, 0, 0,     0, 1, 1, 1);
    add(0, 1, 0, 0, 0,              0, 0, 0,        0, 0, 0,            0, 0,     0, 1, 0, 1);
    add(0, 1, 1, 7, 32'h11,         1, 7, 32'h22,   0, 0, 0,            0, 0,     2, 1, 1, 1);
    add(0, 1, 0, 0, 0,              0, 0, 0,        1, 0, 0,            7, 32'h22, 0, 1, 1, 2);
    add(0, 1, 0, 0, 0,              0, 0, 0,        0, 0, 0,            0, 0,     0, 1, 0, 2);
    add(0, 1, 1, 0, 32'h55,         1, 3, 32'h66,   0, 0, 0,            0, 0,     1, 1, 1, 2);
    add(0, 1, 0, 0, 0,              1, 9, 32'h77,   1, 3, 32'h66,       0, 0,     0, 1, 1, 3);
    add(0, 1, 0, 0, 0,              0, 0, 0,        0, 0, 0,            0, 0,     0, 1, 0, 3);
    add(0, 1, 1, 1, 32'hA1,         1, 2, 32'hA2,   0, 0, 0,            0, 0,     2, 1, 1, 3);
    add(0, 1, 1, 3, 32'hA3,         1, 4, 32'hA4,   1, 1, 32'hA1,       2, 32'hA2, 2, 1, 1, 5);
    add(0, 1, 0, 0, 0,              0, 0, 0,        1, 3, 32'hA3,       4, 32'hA4, 0, 1, 1, 7);
    add(0, 1, 0, 0, 0,              0, 0, 0,        0, 0, 0,            0, 0,     0, 1, 0, 7);

    foreach (vecs[i]) begin
      drive(vecs[i].rst[0], vecs[i].drn[0], vecs[i].c0v[0], AW'(vecs[i].c0a), vecs[i].c0d,
            vecs[i].c1v[0], AW'(vecs[i].c1a), vecs[i].c1d);
      tick();
      chk($sformatf("v%0d.we", i),   32'(write_en),    vecs[i].we);
      chk($sformatf("v%0d.a1", i),   32'(write_addr1), vecs[i].a1);
      chk($sformatf("v%0d.d1", i),   write_data1,      vecs[i].d1);
      chk($sformatf("v%0d.a2", i),   32'(write_addr2), vecs[i].a2);
      chk($sformatf("v%0d.d2", i),   write_data2,      vecs[i].d2);
      chk($sformatf("v%0d.cnt", i),  32'(fifo_count),  vecs[i].cnt);
      chk($sformatf("v%0d.rdy", i),  32'(in_ready),    vecs[i].rdy);
      chk($sformatf("v%0d.pend", i), 32'(pending),     vecs[i].pend);
      chk($sformatf("v%0d.ret", i),  retired_cnt,      vecs[i].ret);
    end

    // Backpressure: fill with drain off, hold a fifth pair, then drain in push order.
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, AW'(10 + 2*k), 32'(256 + 10 + 2*k), 1, AW'(11 + 2*k), 32'(256 + 11 + 2*k));
      tick();
      chk("bp.fill_cnt", 32'(fifo_count), 32'(2*(k+1)));
      chk("bp.fill_we",  32'(write_en),   0);
    end
    chk("bp.full_rdy", 32'(in_ready), 0);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 6'd30, 32'h30, 1, 6'd31, 32'h31);
      tick();
      chk("bp.held_cnt", 32'(fifo_count), 8);
      chk("bp.held_rdy", 32'(in_ready),   0);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, '0, '0, 0, '0, '0);
      tick();
      chk("bp.we",  32'(write_en),    1);
      chk("bp.a1",  32'(write_addr1), 32'(10 + 2*k));
      chk("bp.d1",  write_data1,      32'(256 + 10 + 2*k));
      chk("bp.a2",  32'(write_addr2), 32'(11 + 2*k));
      chk("bp.cnt", 32'(fifo_count),  32'(6 - 2*k));
      chk("bp.rdy", 32'(in_ready),    1);
      chk("bp.ret", retired_cnt,      32'(7 + 2*(k+1)));
    end
    tick();
    chk("bp.idle_we", 32'(write_en), 0);

    // Reset during a drain: six entries queued, one pair written, then reset.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, AW'(20 + 2*k), 32'(20 + 2*k), 1, AW'(21 + 2*k), 32'(21 + 2*k));
      tick();
    end
    chk("rd.cnt6", 32'(fifo_count), 6);
    drive(0, 1, 0, '0, '0, 0, '0, '0);
    tick();
    chk("rd.a1", 32'(write_addr1), 20);
    chk("rd.a2", 32'(write_addr2), 21);
    drive(1, 1, 1, 6'd40, 32'h40, 0, '0, '0);
    tick();
    chk("rd.we",   32'(write_en),   0);
    chk("rd.cnt",  32'(fifo_count), 0);
    chk("rd.ret",  retired_cnt,     0);
    chk("rd.pend", 32'(pending),    0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, '0, '0, 0, '0, '0);
      tick();
      chk("rd.after_we",  32'(write_en),   0);
      chk("rd.after_cnt", 32'(fifo_count), 0);
    end

    // Randomized traffic; small address range to provoke collisions and x0 drops.
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      drain_en = ($urandom_range(0, 99) < ((i < 400) ? 40 : 85));
      c0_valid = $urandom_range(0, 1) == 1;
      c1_valid = $urandom_range(0, 1) == 1;
      c0_addr  = AW'($urandom_range(0, 7));
      c1_addr  = AW'($urandom_range(0, 7));
      c0_data  = $urandom();
      c1_data  = $urandom();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arf_retire_ctrl.md
# arf_retire_ctrl

Commit-side write scheduler for the architectural register file. Accepts up to two retiring results per cycle from the ROB, buffers them in an in-order FIFO, and drains up to two per cycle onto the ARF's two write ports and its shared write enable. Resolves same-address collisions within a write pair and reports pending state so dispatch can stall ARF reads that would see stale data.

## Interface
- AR_SIZE, 6, architectural register address width
- DATA_W, 32, result data width
- DEPTH, 8, FIFO entries; power of two, ≥ 4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- c0_valid  in  1  older commit lane valid
- c0_addr  in  AR_SIZE  older lane destination register
- c0_data  in  DATA_W  older lane result
- c1_valid  in  1  younger commit lane valid; ignored unless c0_valid=1
- c1_addr  in  AR_SIZE  younger lane destination register
- c1_data  in  DATA_W  younger lane result
- in_ready  out  1  controller accepts the current lane pair this cycle
- drain_en  in  1  permits FIFO pops; 0 holds all entries
- write_en  out  1  ARF write enable
- write_addr1  out  AR_SIZE  ARF port 1 address (older write)
- write_data1  out  DATA_W  ARF port 1 data
- write_addr2  out  AR_SIZE  ARF port 2 address (younger write)
- write_data2  out  DATA_W  ARF port 2 data
- pending  out  1  FIFO non-empty or write outputs active
- fifo_count  out  $clog2(DEPTH)+1  occupied entries
- retired_cnt  out  32  total architectural writes issued

## Operation
- Accept: the lane pair is accepted on a rising edge when in_ready=1. in_ready = (DEPTH − fifo_count) ≥ 2, computed from the current count only; same-cycle pops do not free space.
- Push filtering: a lane with valid=1 and addr=0 is dropped, never enqueued (x0 is never written). c1_valid=1 with c0_valid=0 is ignored entirely.
- Push order: c0 is enqueued before c1. Pushes per cycle: 0, 1 or 2.
- Pop: when drain_en=1, pop min(fifo_count, 2) entries from the head. The first entry popped goes to slot 1, the second to slot 2.
- Output registers load every cycle:
  - With ≥1 pop: write_en=1, and slot 1 gets the head entry. Slot 2 gets the second entry, or addr=0 and data=0 if only one entry is popped.
  - With 0 pops: write_en=0, and all addresses and data are 0.
- Collision: if both popped entries share a nonzero address, slot 1 is forced to addr=0 and data=0. The younger entry (slot 2) is the only write. This counts as one write.
- retired_cnt increments by the number of nonzero-address writes loaded into the output registers. It wraps modulo 2^32.
- fifo_count_next = fifo_count + pushes − pops. Pointers wrap modulo DEPTH.
- pending = (fifo_count≠0) | write_en.
- Reset: clears the FIFO, pointers, count and retired_cnt. Outputs are write_en=0, all addr/data=0, fifo_count=0, pending=0, retired_cnt=0, and in_ready=1 from the first cycle after reset. Entries in flight at reset are discarded; no partial write is issued.

## Timing
- Commit accepted at the edge ending cycle 0: entry is at the FIFO head in cycle 1, and write_* are valid in cycle 2 (drain_en=1). The ARF updates at the edge ending cycle 2. Minimum latency is 2 cycles; there is no empty-FIFO bypass.
- Sustained throughput is 2 writes per cycle with drain_en=1.
- Full: fifo_count ≥ DEPTH−1 forces in_ready=0. The ROB must hold both lanes stable until in_ready=1.
- Simultaneous push and pop at full−2 is permitted. Count never exceeds DEPTH and never underflows.
- drain_en low: outputs go idle the next cycle. The FIFO holds, and accepts until full.
- rst asserted in any cycle overrides push and pop in that cycle.

## Test plan
- Reset: assert rst 2 cycles with c0_valid=1 -> write_en=0, fifo_count=0, in_ready=1, retired_cnt=0, and nothing enqueued.
- Single commit: c0=(5, 0xDEADBEEF) at cycle 0 -> cycle 2 write_en=1, addr1=5, data1=0xDEADBEEF, addr2=0; retired_cnt=1; pending=0 in cycle 3.
- Collision: pair (7, 0x11),(7, 0x22) -> one cycle with addr1=0, addr2=7, data2=0x22; retired_cnt increments by 1.
- Backpressure: drain_en=0, push 4 pairs with DEPTH=8 -> in_ready=0 once count ≥ 7 (after 4th pair count=8); 5th pair held. Raise drain_en -> 4 cycles of paired writes in push order, then in_ready=1.
- Filtering: pair (0, 0x55),(3, 0x66), then c1_valid alone -> only addr 3 is written, in slot 1 with addr2=0; fifo_count peaks at 1.
- Reset mid-drain: FIFO holds 6 entries, assert rst during a drain -> the next cycle write_en=0, fifo_count=0, and no further writes occur.
